usb_unpacker: RTL and testbench

USB_UNPACKER -- requirements
Module: usb_unpacker

---
 rtl/memfifo_pkg.sv | 21 ++
 rtl/usb_unpacker.sv | 101 ++++++++++
 tb/tb_usb_unpacker.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memfifo_pkg.sv
// Shared widths and state encoding for the
// 128-bit FIFO to 16-bit EZ-USB unpacker.
package memfifo_pkg;

  localparam int USB_WIDTH  = 16;
  localparam int FIFO_WIDTH = 128;
  localparam int SUBWORDS   = 8;
  localparam int IDX_WIDTH  = $clog2(SUBWORDS);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic logic [USB_WIDTH-1:0] swap16(
    input logic [USB_WIDTH-1:0] w
  );
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/usb_unpacker.sv
// Splits FWFT FIFO 128-bit words into eight
// 16-bit sub-words, low lane first.
module usb_unpacker
  import memfifo_pkg::*;
#(
  parameter bit SWAP_BYTES = 1'b0,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  ifclk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [127:0]          fifo_do,
  input  logic                  fifo_empty,
  output logic                  fifo_rden,
  output logic [15:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy
);

  state_e                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [FIFO_WIDTH-1:0]   sr_q, sr_d;
  logic                    rden_q, rden_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    busy_q, busy_d;

  logic xfer;
  logic last;
  logic can_load;

  assign xfer     = (state_q == STREAM) && out_ready;
  assign last     = xfer && (idx_q == IDX_WIDTH'(SUBWORDS - 1));
  assign can_load = enable && !fifo_empty;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    rden_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (can_load) begin
          state_d = STREAM;
          sr_d    = fifo_do;
          idx_d   = '0;
          rden_d  = 1'b1;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
      end
      STREAM: begin
        if (xfer) begin
          sr_d  = sr_q >> USB_WIDTH;
          idx_d = idx_q + IDX_WIDTH'(1);
        end
        // Reload on the last lane avoids a bubble
        if (last) begin
          if (can_load) begin
            sr_d   = fifo_do;
            idx_d  = '0;
            rden_d = 1'b1;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == STREAM);
  end

  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sr_q    <= '0;
      rden_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      rden_q  <= rden_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Drained shift register is all zero, so IDLE shows 0
  assign out_data  = SWAP_BYTES ? swap16(sr_q[15:0])
                                : sr_q[15:0];
  assign out_valid = (state_q == STREAM);
  assign fifo_rden = rden_q;
  assign word_cnt  = cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_usb_unpacker.sv
// Scoreboard bench for usb_unpacker: a queue
// FIFO model feeds the DUT, expected lanes are popped.
module tb_usb_unpacker;

  logic         ifclk;
  logic         reset_n;
  logic         enable;
  logic [127:0] fifo_do;
  logic         fifo_empty;
  logic         fifo_rden;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  word_cnt;
  logic         busy;

  logic         enable2;
  logic [127:0] fifo_do2;
  logic         fifo_empty2;
  logic         fifo_rden2;
  logic [15:0]  out_data2;
  logic         out_valid2;
  logic         out_ready2;
  logic [3:0]   word_cnt2;
  logic         busy2;

  logic [127:0] fq[$];
  logic [15:0]  exp_q[$];
  int           n_chk;
  int           n_fail;
  logic [31:0]  exp_cnt;

  usb_unpacker u_dut (
    .ifclk      (ifclk),
    .reset_n    (reset_n),
    .enable     (enable),
    .fifo_do    (fifo_do),
    .fifo_empty (fifo_empty),
    .fifo_rden  (fifo_rden),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .word_cnt   (word_cnt),
    .busy       (busy)
  );

  usb_unpacker #(
    .SWAP_BYTES (1'b1),
    .CNT_WIDTH  (4)
  ) u_dut2 (
    .ifclk      (ifclk),
    .reset_n    (reset_n),
    .enable     (enable2),
    .fifo_do    (fifo_do2),
    .fifo_empty (fifo_empty2),
    .fifo_rden  (fifo_rden2),
    .out_data   (out_data2),
    .out_valid  (out_valid2),
    .out_ready  (out_ready2),
    .word_cnt   (word_cnt2),
    .busy       (busy2)
  );

  always #5 ifclk = ~ifclk;

  task automatic refresh();
    if (fq.size() == 0) begin
      fifo_empty = 1'b1;
      fifo_do    = '0;
    end else begin
      fifo_empty = 1'b0;
      fifo_do    = fq[0];
    end
  endtask

  function automatic logic [127:0] mk_word(
    input logic [7:0] tag
  );
    logic [127:0] w;
    for (int i = 0; i < 8; i++)
      w[i*16 +: 16] = {tag, 8'(i)};
    return w;
  endfunction

  task automatic fifo_push(
    input logic [127:0] w,
    input bit           expect_out
  );
    fq.push_back(w);
    if (expect_out)
      for (int i = 0; i < 8; i++)
        exp_q.push_back(w[i*16 +: 16]);
    refresh();
  endtask

  // FWFT FIFO model: pop one edge after the strobe
  always @(posedge ifclk) begin
    bit pop;
    pop = fifo_rden;
    #1;
    if (pop && fq.size() != 0)
      void'(fq.pop_front());
    refresh();
  end

  always @(negedge ifclk) begin
    if (reset_n && out_valid && out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got %h want none",
                 out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL sb_data: got %h want %h",
                   out_data, e);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge ifclk);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %b want 0", out_valid);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy: got %b want 0", busy);
    end
    n_chk++;
    if (fifo_rden !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rden: got %b want 0", fifo_rden);
    end
    n_chk++;
    if (word_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_cnt: got %0d want 0", word_cnt);
    end
    n_chk++;
    if (out_data !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_data: got %h want 0", out_data);
    end
    @(negedge ifclk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int vcnt;
    int rcnt;
    out_ready = 1'b1;
    enable    = 1'b1;
    @(negedge ifclk);
    fifo_push(mk_word(8'h00), 1'b1);
    exp_cnt = exp_cnt + 1;
    @(negedge ifclk);
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: got %b want 1",
               out_valid);
    end
    n_chk++;
    if (fifo_rden !== 1'b1) begin
      n_fail++;
      $display("FAIL single_rden0: got %b want 1",
               fifo_rden);
    end
    vcnt = 1;
    rcnt = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge ifclk);
      if (out_valid) vcnt++;
      if (fifo_rden) rcnt++;
    end
    n_chk++;
    if (vcnt != 8) begin
      n_fail++;
      $display("FAIL single_vcnt: got %0d want 8", vcnt);
    end
    n_chk++;
    if (rcnt != 1) begin
      n_fail++;
      $display("FAIL single_rcnt: got %0d want 1", rcnt);
    end
    n_chk++;
    if (word_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL single_cnt: got %0d want %0d",
               word_cnt, exp_cnt);
    end
    n_chk++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b left=%0d want 0 0",
               busy, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int vcnt;
    int first;
    int last;
    int rk;
    enable = 1'b0;
    for (int w = 1; w <= 4; w++)
      fifo_push(mk_word(8'(w)), 1'b1);
    exp_cnt = exp_cnt + 4;
    @(negedge ifclk);
    enable = 1'b1;
    vcnt  = 0;
    first = -1;
    last  = -1;
    rk    = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge ifclk);
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        vcnt++;
      end
      if (fifo_rden) begin
        n_chk++;
        if (c - first != 8 * rk) begin
          n_fail++;
          $display("FAIL b2b_rden_pos: got %0d want %0d",
                   c - first, 8 * rk);
        end
        rk++;
      end
    end
    n_chk++;
    if (vcnt != 32 || last - first != 31) begin
      n_fail++;
      $display("FAIL b2b_gapless: got %0d/%0d want 32/31",
               vcnt, last - first);
    end
    n_chk++;
    if (rk != 4) begin
      n_fail++;
      $display("FAIL b2b_rcnt: got %0d want 4", rk);
    end
    n_chk++;
    if (word_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL b2b_cnt: got %0d want %0d",
               word_cnt, exp_cnt);
    end
  endtask

  task automatic test_stall();
    bit          stalled;
    logic [15:0] held;
    int          nstall;
    stalled = 1'b0;
    nstall  = 0;
    held    = '0;
    fifo_push(mk_word(8'h21), 1'b1);
    fifo_push(mk_word(8'h22), 1'b1);
    exp_cnt = exp_cnt + 2;
    for (int c = 0; c < 200; c++) begin
      @(posedge ifclk);
      #1;
      if (c < 8)
        out_ready = (c % 4 == 0) || (c % 4 == 3);
      else
        out_ready = 1'($urandom_range(0, 1));
      @(negedge ifclk);
      if (stalled) begin
        nstall++;
        n_chk++;
        if (out_data !== held || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold: got %h/%b want %h/1",
                   out_data, out_valid, held);
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (c > 2 && !busy && exp_q.size() == 0) break;
    end
    @(posedge ifclk);
    #1 out_ready = 1'b1;
    n_chk++;
    if (exp_q.size() != 0 || nstall == 0) begin
      n_fail++;
      $display("FAIL stall_done: got left=%0d stalls=%0d want 0 >0",
               exp_q.size(), nstall);
    end
    n_chk++;
    if (word_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d want %0d",
               word_cnt, exp_cnt);
    end
  endtask

  task automatic test_enable_drop();
    int vcnt;
    int rcnt;
    enable = 1'b0;
    fifo_push(mk_word(8'h31), 1'b1);
    fifo_push(mk_word(8'h32), 1'b0);
    exp_cnt = exp_cnt + 1;
    @(negedge ifclk);
    enable = 1'b1;
    vcnt = 0;
    rcnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge ifclk);
      if (out_valid) vcnt++;
      if (fifo_rden) rcnt++;
      if (vcnt == 4) enable = 1'b0;
    end
    n_chk++;
    if (vcnt != 8) begin
      n_fail++;
      $display("FAIL endrop_vcnt: got %0d want 8", vcnt);
    end
    n_chk++;
    if (rcnt != 1 || fq.size() != 1) begin
      n_fail++;
      $display("FAIL endrop_pop: got %0d/%0d want 1/1",
               rcnt, fq.size());
    end
    n_chk++;
    if (busy !== 1'b0 || word_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL endrop_end: got %b/%0d want 0/%0d",
               busy, word_cnt, exp_cnt);
    end
    fq.delete();
    refresh();
  endtask

  task automatic test_reset_mid();
    logic [127:0] wa;
    logic [127:0] wb;
    int           vcnt;
    int           rcnt;
    bit           hit;
    wa = mk_word(8'h41);
    wb = mk_word(8'h42);
    enable = 1'b0;
    fifo_push(wa, 1'b1);
    fifo_push(wb, 1'b0);
    @(negedge ifclk);
    enable = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ifclk);
      if (out_valid && out_data == wa[5*16 +: 16]) begin
        hit = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rmid_reach: got 0 want sub-word 5");
    end
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_valid: got %b/%b want 0/0",
               out_valid, busy);
    end
    n_chk++;
    if (out_data !== 16'h0 || fifo_rden !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_data: got %h/%b want 0/0",
               out_data, fifo_rden);
    end
    n_chk++;
    if (word_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rmid_cnt0: got %0d want 0", word_cnt);
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++)
      exp_q.push_back(wb[i*16 +: 16]);
    exp_cnt = 1;
    @(negedge ifclk);
    @(negedge ifclk);
    reset_n = 1'b1;
    vcnt = 0;
    rcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ifclk);
      if (out_valid) vcnt++;
      if (fifo_rden) rcnt++;
    end
    n_chk++;
    if (vcnt != 8 || rcnt != 1) begin
      n_fail++;
      $display("FAIL rmid_after: got %0d/%0d want 8/1",
               vcnt, rcnt);
    end
    n_chk++;
    if (word_cnt !== exp_cnt || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rmid_cnt: got %0d/%0d want %0d/0",
               word_cnt, exp_q.size(), exp_cnt);
    end
  endtask

  task automatic test_wrap_swap();
    int r2;
    int bad;
    int v2;
    r2  = 0;
    bad = 0;
    v2  = 0;
    @(negedge ifclk);
    enable2 = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge ifclk);
      if (fifo_rden2) r2++;
      if (r2 == 17) enable2 = 1'b0;
      if (out_valid2) begin
        v2++;
        if (out_data2 !== 16'h3412) bad++;
      end
      if (!enable2 && !busy2) break;
    end
    n_chk++;
    if (r2 != 17 || v2 != 136) begin
      n_fail++;
      $display("FAIL wrap_pops: got %0d/%0d want 17/136",
               r2, v2);
    end
    n_chk++;
    if (word_cnt2 !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap_cnt: got %0d want 1", word_cnt2);
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL swap_data: got %0d bad lanes want 0",
               bad);
    end
  endtask

  initial begin
    ifclk       = 1'b0;
    reset_n     = 1'b0;
    enable      = 1'b0;
    out_ready   = 1'b0;
    enable2     = 1'b0;
    out_ready2  = 1'b1;
    fifo_empty2 = 1'b0;
    fifo_do2    = {8{16'h1234}};
    n_chk       = 0;
    n_fail      = 0;
    exp_cnt     = 0;
    refresh();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_enable_drop();
    test_reset_mid();
    test_wrap_swap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
